// File: rtl/rptr_empty_ctrl.sv
// Read-side pointer, empty/almost-empty, fill level and underflow tracking for the async FIFO (rclk domain).
// Latency: all outputs registered; a new synchronized write pointer is reflected one rclk edge later.
// Backpressure: reads are ignored while empty and instead set the sticky underflow flag.
module rptr_empty_ctrl #(
    parameter int ADDRSIZE      = 4,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rinc,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic                rclr_uflow,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                raempty,
    output logic [ADDRSIZE:0]   rcount,
    output logic                runderflow
);

    localparam logic [ADDRSIZE:0] LP_AE_THRESH = AEMPTY_THRESH[ADDRSIZE:0];

    logic [ADDRSIZE:0] r_bin;
    logic [ADDRSIZE:0] r_gray;
    logic              r_empty;
    logic              r_aempty;
    logic [ADDRSIZE:0] r_count;
    logic              r_uflow;

    logic              w_rd_en;
    logic [ADDRSIZE:0] w_rbinnext;
    logic [ADDRSIZE:0] w_rgraynext;
    logic [ADDRSIZE:0] w_wbin_s;
    logic [ADDRSIZE:0] w_fill;

    assign w_rd_en     = rinc & ~r_empty;
    assign w_rbinnext  = r_bin + {{ADDRSIZE{1'b0}}, w_rd_en};
    assign w_rgraynext = (w_rbinnext >> 1) ^ w_rbinnext;

    // Each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        w_wbin_s = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            w_wbin_s[i] = ^(rq2_wptr >> i);
        end
    end

    // Uses the stale synchronized write pointer, so the level can only under-report.
    assign w_fill = w_wbin_s - w_rbinnext;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_bin    <= '0;
            r_gray   <= '0;
            r_empty  <= 1'b1;
            r_aempty <= 1'b1;
            r_count  <= '0;
            r_uflow  <= 1'b0;
        end else begin
            r_bin    <= w_rbinnext;
            r_gray   <= w_rgraynext;
            r_empty  <= (w_rgraynext == rq2_wptr);
            r_aempty <= (w_fill <= LP_AE_THRESH);
            r_count  <= w_fill;
            if (rinc && r_empty) begin
                r_uflow <= 1'b1;
            end else if (rclr_uflow) begin
                r_uflow <= 1'b0;
            end
        end
    end

    assign raddr      = r_bin[ADDRSIZE-1:0];
    assign rptr       = r_gray;
    assign rempty     = r_empty;
    assign raempty    = r_aempty;
    assign rcount     = r_count;
    assign runderflow = r_uflow;

endmodule

// File: tb/tb_rptr_empty_ctrl.sv
// Bench for rptr_empty_ctrl: directed vector table, fill/drain, async reset and random traffic vs. a count-based model.
module tb_rptr_empty_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          rclk = 1'b0;
    logic          rrst_n = 1'b1;
    logic          rinc = 1'b0;
    logic [AW:0]   rq2_wptr = '0;
    logic          rclr_uflow = 1'b0;
    logic [AW-1:0] raddr;
    logic [AW:0]   rptr;
    logic          rempty;
    logic          raempty;
    logic [AW:0]   rcount;
    logic          runderflow;

    rptr_empty_ctrl #(.ADDRSIZE(AW), .AEMPTY_THRESH(2)) dut (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .rinc       (rinc),
        .rq2_wptr   (rq2_wptr),
        .rclr_uflow (rclr_uflow),
        .raddr      (raddr),
        .rptr       (rptr),
        .rempty     (rempty),
        .raempty    (raempty),
        .rcount     (rcount),
        .runderflow (runderflow)
    );

    always #5 rclk = ~rclk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: total writes visible through rq2_wptr and total reads performed.
    int m_w = 0;
    int m_r = 0;
    bit m_empty = 1'b1;
    bit m_uflow = 1'b0;
    logic [AW:0] prev_rptr = '0;

    typedef struct {
        bit rinc;
        int w;
        bit clr;
        int e_rptr;
        int e_raddr;
        bit e_empty;
        bit e_aempty;
        int e_count;
        bit e_uflow;
    } vec_t;

    function automatic logic [AW:0] gray_of(input int n);
        logic [AW:0] b;
        b = n[AW:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("rptr",    int'(rptr),       int'(gray_of(m_r)));
        chk("raddr",   int'(raddr),      m_r % DEPTH);
        chk("rempty",  int'(rempty),     int'(m_empty));
        chk("rcount",  int'(rcount),     m_w - m_r);
        chk("raempty", int'(raempty),    int'((m_w - m_r) <= 2));
        chk("runderflow", int'(runderflow), int'(m_uflow));
        chk("rptr_onebit", int'($countones(rptr ^ prev_rptr) <= 1), 1);
        prev_rptr = rptr;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rptr"},    int'(rptr),       0);
        chk({tag, "_raddr"},   int'(raddr),      0);
        chk({tag, "_rempty"},  int'(rempty),     1);
        chk({tag, "_raempty"}, int'(raempty),    1);
        chk({tag, "_rcount"},  int'(rcount),     0);
        chk({tag, "_uflow"},   int'(runderflow), 0);
    endtask

    // Present inputs for one cycle, advance the model at the edge, then compare.
    task automatic step(input bit ri, input int w, input bit clr);
        rinc       = ri;
        m_w        = w;
        rq2_wptr   = gray_of(w);
        rclr_uflow = clr;
        @(posedge rclk);
        if (ri && m_empty) m_uflow = 1'b1;
        else if (clr)      m_uflow = 1'b0;
        if (ri && !m_empty) m_r++;
        m_empty = (m_w == m_r);
        #1;
        chk_model();
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{0, 1, 0, 0, 0, 0, 1, 1, 0};
        vecs[1] = '{1, 1, 0, 1, 1, 1, 1, 0, 0};
        vecs[2] = '{1, 1, 0, 1, 1, 1, 1, 0, 1};
        vecs[3] = '{1, 1, 1, 1, 1, 1, 1, 0, 1};
        vecs[4] = '{0, 1, 1, 1, 1, 1, 1, 0, 0};
        vecs[5] = '{0, 2, 0, 1, 1, 0, 1, 1, 0};
        vecs[6] = '{0, 3, 0, 1, 1, 0, 1, 2, 0};
        vecs[7] = '{0, 4, 0, 1, 1, 0, 0, 3, 0};
        vecs[8] = '{1, 4, 0, 3, 2, 0, 1, 2, 0};
        vecs[9] = '{1, 5, 0, 2, 3, 0, 1, 2, 0};

        #1 rrst_n = 1'b0;
        #1;
        chk_reset_vals("rst_async");
        #10 rrst_n = 1'b1;
        @(posedge rclk);
        #1;
        chk_reset_vals("rst_idle");

        // Directed vectors: single entry, underflow set/clear priority, almost-empty, simultaneous read+write.
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].rinc, vecs[i].w, vecs[i].clr);
            chk($sformatf("v%0d_rptr", i),   int'(rptr),       vecs[i].e_rptr);
            chk($sformatf("v%0d_raddr", i),  int'(raddr),      vecs[i].e_raddr);
            chk($sformatf("v%0d_empty", i),  int'(rempty),     int'(vecs[i].e_empty));
            chk($sformatf("v%0d_aempty", i), int'(raempty),    int'(vecs[i].e_aempty));
            chk($sformatf("v%0d_count", i),  int'(rcount),     vecs[i].e_count);
            chk($sformatf("v%0d_uflow", i),  int'(runderflow), int'(vecs[i].e_uflow));
        end

        // Drain, then fill to full and drain back to empty.
        while (m_w != m_r) step(1, m_w, 0);
        for (int i = 0; i < DEPTH; i++) step(0, m_w + 1, 0);
        chk("full_count", int'(rcount), DEPTH);
        chk("full_empty", int'(rempty), 0);
        for (int i = 0; i < DEPTH; i++) step(1, m_w, 0);
        chk("drain_empty", int'(rempty), 1);
        chk("drain_count", int'(rcount), 0);

        // Write/read pairs across the pointer wrap, draining to empty each time.
        for (int i = 0; i < 40; i++) begin
            step(0, m_w + 1, 0);
            step(1, m_w, 0);
            chk("wrap_empty", int'(rempty), 1);
        end

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            int nw;
            nw = m_w;
            if ((m_w - m_r) < DEPTH && ($urandom % 2) == 0) nw = m_w + 1;
            step(($urandom % 3) != 0, nw, ($urandom % 8) == 0);
        end

        // Async reset with seven entries held.
        while (m_w != m_r) step(1, m_w, 0);
        step(0, m_w, 1);
        for (int i = 0; i < 7; i++) step(0, m_w + 1, 0);
        chk("pre_rst_count", int'(rcount), 7);
        #3 rrst_n = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        repeat (2) @(posedge rclk);
        #1;
        chk_reset_vals("mid_rst_hold");
        rinc     = 1'b0;
        rq2_wptr = '0;
        m_w = 0; m_r = 0; m_empty = 1'b1; m_uflow = 1'b0; prev_rptr = '0;
        #2 rrst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            int nw;
            nw = m_w;
            if ((m_w - m_r) < DEPTH && ($urandom % 2) == 0) nw = m_w + 1;
            step(($urandom % 2) != 0, nw, ($urandom % 6) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
